axi_core_mem_master: RTL and testbench
======================================

// Module: axi_core_mem_master
// PURPOSE
//   AXI4 manager (initiator) that turns a simple single-request core memory port into single-beat AXI4 transactions.
//   It is the requesting end for the AXI memory responders in rv64g_ss (TCDM RAM, DMA slave port).
//   One transaction is outstanding at a time.
//   AxLEN=0, AxSIZE=log2(DATA_WIDTH/8), AxBURST=INCR and AxID=0 are constants, tied off where the channels are packed into req_t.
// PARAMETERS
//   ADDR_WIDTH   64  byte address width of req_addr_i, aw_addr_o, ar_addr_o
//   DATA_WIDTH   64  data width in bits; strobe width is DATA_WIDTH/8
//   ALIGN_CHECK  1   1: an address not aligned to DATA_WIDTH/8 is answered with an error and never reaches AXI
// PORTS
//   clk_i                 in   1             clock, all logic on rising edge
//   srst_i                in   1             synchronous reset, active-high
//   req_valid_i/ready_o   in/out 1/1         core request handshake
//   req_we_i              in   1             1=write, 0=read
//   req_addr_i            in   ADDR_WIDTH    byte address
//   req_wdata_i           in   DATA_WIDTH    write data
//   req_strb_i            in   DATA_WIDTH/8  write byte strobes
//   rsp_valid_o           out  1             one-cycle completion pulse (no backpressure)
//   rsp_rdata_o           out  DATA_WIDTH    read data
//   rsp_err_o             out  1             completion had an error
//   aw_valid_o/ready_i    out/in 1/1         AW handshake
//   aw_addr_o             out  ADDR_WIDTH    write address
//   w_valid_o/ready_i     out/in 1/1         W handshake
//   w_data_o, w_strb_o    out  DATA_WIDTH, DATA_WIDTH/8  write beat
//   w_last_o              out  1             constant 1
//   b_valid_i/ready_o     in/out 1/1         B handshake
//   b_resp_i              in   2             write response
//   ar_valid_o/ready_i    out/in 1/1         AR handshake
//   ar_addr_o             out  ADDR_WIDTH    read address
//   r_valid_i/ready_o     in/out 1/1         R handshake
//   r_data_i, r_resp_i    in   DATA_WIDTH, 2 read beat and response
//   r_last_i              in   1             last read beat
// BEHAVIOUR
// - Reset values:
//   - State goes to IDLE.
//   - All *_valid_o and b_ready_o/r_ready_o are 0.
//   - rsp_valid_o, rsp_err_o, rsp_rdata_o are 0.
//   - Address/data registers are 0.
//   - req_ready_o is 0 while srst_i=1.
// - FSM states: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RESP.
// - IDLE:
//   - req_ready_o=1.
//   - On req_valid_i&&req_ready_o, addr/wdata/strb/we are registered.
//   - If ALIGN_CHECK is set and the address is misaligned -> RESP with err=1.
//   - Otherwise we=1 -> WR, we=0 -> RD_ADDR.
//   - req_ready_o=0 in every other state.
// - WR:
//   - aw_valid_o and w_valid_o rise together.
//   - Each channel drops independently after its own handshake, tracked by aw_done/w_done flags.
//   - Move to WR_RESP in the cycle where both are done (same cycle if both readies are high).
// - WR_RESP:
//   - b_ready_o=1.
//   - On b_valid_i, err=b_resp_i[1] (SLVERR/DECERR) -> RESP.
// - RD_ADDR: ar_valid_o=1 until ar_ready_i -> RD_DATA.
// - RD_DATA:
//   - r_ready_o=1.
//   - On each r_valid_i, r_data_i is captured and err |= r_resp_i[1].
//   - If r_last_i=0, set err=1 and stay in RD_DATA, draining beats until r_last_i=1; the first beat's data is kept.
// - RESP:
//   - rsp_valid_o=1 for exactly one cycle -> IDLE.
//   - rsp_rdata_o=captured data for reads and 0 for writes or misaligned requests.
//   - rsp_err_o=err.
//   - rsp_rdata_o/rsp_err_o hold their value until the next RESP.
// - AXI stability: while a valid is high and not yet accepted, its addr/data/strb stay constant.
// - Minimum latency, request accept (cycle 0) to rsp_valid_o:
//   - Write: 3 cycles (WR c1, WR_RESP c2, RESP c3).
//   - Read: 3 cycles.
//   - Misaligned: 1 cycle.
// - In IDLE/RESP/WR/RD_ADDR, b_ready_o=r_ready_o=0, so stray b_valid_i/r_valid_i are not consumed.
// - Reset mid-transaction: immediately returns to IDLE and drops all valids.
//   Responders in the subsystem share this reset, so no orphan transaction survives.
// TESTING
// - Write: addr 0x1000, wdata 0xDEADBEEF_CAFEF00D, strb 0xFF; AW/W ready=1, b_resp=0 -> aw_addr_o=0x1000; rsp_valid_o on cycle 3; err=0.
// - Read: addr 0x1008; ar_ready delayed 4 cycles; r_data=0x1234, resp=0, last=1 -> ar_addr_o held stable 5 cycles; rsp_rdata_o=0x1234; err=0.
// - W accepted 3 cycles before AW -> w_valid_o drops after its handshake; WR_RESP entered only once AW is accepted; exactly one AW and one W beat.
// - Error: b_resp=2'b10 on write, then r_resp=2'b11 on read -> rsp_err_o=1 for both; next OKAY read gives err=0.
// - Misaligned addr 0x1003 with ALIGN_CHECK=1 -> rsp_valid_o at cycle 1 with err=1; no aw/ar/w valid ever asserted.
// - srst_i=1 while in WR_RESP -> next cycle all valids=0 and req_ready_o=1 after release; b_valid_i ignored; a new read completes normally.

Source files
------------

// File: rtl/axi_core_mem_master.sv
// Single-outstanding AXI4 manager: converts a simple core request/response port
// into single-beat AXI4 write (AW+W+B) or read (AR+R) transactions.
module axi_core_mem_master #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   req_strb_i,
    output logic                      rsp_valid_o,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [ADDR_WIDTH-1:0]     aw_addr_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic [DATA_WIDTH-1:0]     w_data_o,
    output logic [DATA_WIDTH/8-1:0]   w_strb_o,
    output logic                      w_last_o,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    input  logic [1:0]                b_resp_i,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    output logic [ADDR_WIDTH-1:0]     ar_addr_o,
    input  logic                      r_valid_i,
    output logic                      r_ready_o,
    input  logic [DATA_WIDTH-1:0]     r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  beat_seen;
    logic                  misaligned;
    logic                  unused_resp_bits;

    // Only bit 1 of xRESP distinguishes an error (SLVERR/DECERR) from OKAY/EXOKAY.
    assign unused_resp_bits = b_resp_i[0] ^ r_resp_i[0];

    assign misaligned = ALIGN_CHECK && ((req_addr_i & ALIGN_MASK) != '0);

    assign aw_addr_o = addr_q;
    assign ar_addr_o = addr_q;
    assign w_data_o  = wdata_q;
    assign w_strb_o  = strb_q;
    assign w_last_o  = 1'b1;

    always_comb begin
        state_next  = state;
        req_ready_o = 1'b0;
        aw_valid_o  = 1'b0;
        w_valid_o   = 1'b0;
        b_ready_o   = 1'b0;
        ar_valid_o  = 1'b0;
        r_ready_o   = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = !srst_i;
                if (req_valid_i) begin
                    if (misaligned)    state_next = RESP;
                    else if (req_we_i) state_next = WR;
                    else               state_next = RD_ADDR;
                end
            end
            WR: begin
                aw_valid_o = !aw_done;
                w_valid_o  = !w_done;
                if ((aw_done || aw_ready_i) && (w_done || w_ready_i))
                    state_next = WR_RESP;
            end
            WR_RESP: begin
                b_ready_o = 1'b1;
                if (b_valid_i) state_next = RESP;
            end
            RD_ADDR: begin
                ar_valid_o = 1'b1;
                if (ar_ready_i) state_next = RD_DATA;
            end
            RD_DATA: begin
                r_ready_o = 1'b1;
                if (r_valid_i && r_last_i) state_next = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            beat_seen   <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q    <= req_addr_i;
                        wdata_q   <= req_wdata_i;
                        strb_q    <= req_strb_i;
                        err_q     <= 1'b0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        beat_seen <= 1'b0;
                        if (misaligned) begin
                            rsp_rdata_o <= '0;
                            rsp_err_o   <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (aw_valid_o && aw_ready_i) aw_done <= 1'b1;
                    if (w_valid_o && w_ready_i)   w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (b_valid_i) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= b_resp_i[1];
                    end
                end
                RD_DATA: begin
                    // Extra beats of an unexpected burst are drained; only the first beat's data is returned.
                    if (r_valid_i) begin
                        if (!beat_seen) rdata_q <= r_data_i;
                        beat_seen <= 1'b1;
                        err_q     <= err_q | r_resp_i[1] | !r_last_i;
                        if (r_last_i) begin
                            rsp_rdata_o <= beat_seen ? rdata_q : r_data_i;
                            rsp_err_o   <= err_q | r_resp_i[1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_core_mem_master.sv
// Bench for axi_core_mem_master: table-driven and random single transactions
// against a behavioural AXI responder and a latency/response model.
module tb_axi_core_mem_master;

    logic        clk = 1'b0;
    logic        srst;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_strb;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic [63:0] aw_addr, w_data, ar_addr, r_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [1:0]  b_resp, r_resp;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    axi_core_mem_master #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ALIGN_CHECK(1'b1)) dut (
        .clk_i(clk), .srst_i(srst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
        .w_last_o(w_last),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp),
        .r_last_i(r_last)
    );

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        int          aw_dly, w_dly, ar_dly, b_dly, r_dly, extra;
        logic [1:0]  bresp, rresp;
        logic [63:0] rdata;
        int          exp_lat;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [7:0] strb, input int awd, input int wd, input int ard,
                                input int bd, input int rd, input int ex, input logic [1:0] br,
                                input logic [1:0] rr, input logic [63:0] rdata, input int lat,
                                input logic err, input logic [63:0] erd);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.aw_dly = awd; v.w_dly = wd; v.ar_dly = ard; v.b_dly = bd; v.r_dly = rd; v.extra = ex;
        v.bresp = br; v.rresp = rr; v.rdata = rdata;
        v.exp_lat = lat; v.exp_err = err; v.exp_rdata = erd;
        return v;
    endfunction

    // Reference model: completion timing and result derived from the transaction rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.addr[2:0] != 3'd0) begin
            r.exp_lat = 1; r.exp_err = 1'b1; r.exp_rdata = '0;
        end else if (v.we) begin
            r.exp_lat   = ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 3 + v.b_dly;
            r.exp_err   = v.bresp[1];
            r.exp_rdata = '0;
        end else begin
            r.exp_lat   = v.ar_dly + 3 + v.r_dly + v.extra;
            r.exp_err   = v.rresp[1] | (v.extra != 0);
            r.exp_rdata = v.rdata;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string name);
        int   aw_hs = 0, w_hs = 0, ar_hs = 0, ar_cyc = 0;
        int   aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0, beat = 0;
        int   got_lat = 0, bad = 0;
        bit   done = 0, b_sent = 0, mis;
        logic got_err = 1'b0;
        logic [63:0] got_rdata = '0;
        int   exp_aw, exp_w, exp_ar, exp_arc;
        mis = (v.addr[2:0] != 3'd0);
        check({name, " ready"}, 128'(req_ready), 128'(1));
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_strb = v.strb;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            if (rsp_valid) begin
                got_lat = cyc; got_err = rsp_err; got_rdata = rsp_rdata; done = 1;
                aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0; r_last = 0;
            end else begin
                if (req_ready) bad++;
                if (v.we && (ar_valid || r_ready)) bad++;
                if (!v.we && (aw_valid || w_valid || b_ready)) bad++;
                if (mis && (aw_valid || w_valid || ar_valid || b_ready || r_ready)) bad++;
                if (b_ready && !(aw_hs > 0 && w_hs > 0)) bad++;
                if (r_ready && ar_hs == 0) bad++;
                b_valid = 0;
                if (!b_sent && aw_hs > 0 && w_hs > 0) begin
                    if (b_wait >= v.b_dly) begin
                        b_valid = 1; b_resp = v.bresp;
                        if (b_ready) b_sent = 1;
                    end else b_wait++;
                end
                r_valid = 0; r_last = 0;
                if (ar_hs > 0 && beat <= v.extra) begin
                    if (r_wait >= v.r_dly) begin
                        r_valid = 1; r_resp = v.rresp; r_last = (beat == v.extra);
                        r_data = (beat == 0) ? v.rdata : ~v.rdata ^ 64'(beat);
                        if (r_ready) beat++;
                    end else r_wait++;
                end
                aw_ready = 0; w_ready = 0; ar_ready = 0;
                if (aw_valid) begin
                    if (aw_addr !== v.addr) bad++;
                    aw_ready = (aw_wait >= v.aw_dly); aw_wait++;
                    if (aw_ready) aw_hs++;
                end
                if (w_valid) begin
                    if (w_data !== v.wdata || w_strb !== v.strb || w_last !== 1'b1) bad++;
                    w_ready = (w_wait >= v.w_dly); w_wait++;
                    if (w_ready) w_hs++;
                end
                if (ar_valid) begin
                    if (ar_addr !== v.addr) bad++;
                    ar_cyc++;
                    ar_ready = (ar_wait >= v.ar_dly); ar_wait++;
                    if (ar_ready) ar_hs++;
                end
            end
            @(negedge clk);
        end
        if (!done) begin
            check({name, " timeout"}, 128'(0), 128'(1));
            return;
        end
        exp_aw  = (!mis && v.we) ? 1 : 0;
        exp_w   = exp_aw;
        exp_ar  = (!mis && !v.we) ? 1 : 0;
        exp_arc = exp_ar ? v.ar_dly + 1 : 0;
        check({name, " latency"}, 128'(got_lat), 128'(v.exp_lat));
        check({name, " err"}, 128'(got_err), 128'(v.exp_err));
        check({name, " rdata"}, 128'(got_rdata), 128'(v.exp_rdata));
        check({name, " protocol"}, 128'(bad), 128'(0));
        check({name, " handshakes"}, 128'({8'(aw_hs), 8'(w_hs), 8'(ar_hs), 8'(ar_cyc)}),
              128'({8'(exp_aw), 8'(exp_w), 8'(exp_ar), 8'(exp_arc)}));
        check({name, " hold"}, 128'({rsp_valid, rsp_err, rsp_rdata, req_ready}),
              128'({1'b0, v.exp_err, v.exp_rdata, 1'b1}));
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0,0,0,0,0,0, 2'b00,2'b00, 64'h0,    3,0,64'h0);
        tbl[1]  = mk(0, 64'h1008, 64'h0, 8'h00, 0,0,4,0,0,0, 2'b00,2'b00, 64'h1234,                  7,0,64'h1234);
        tbl[2]  = mk(1, 64'h1010, 64'h01234567_89ABCDEF, 8'hF0, 3,0,0,0,0,0, 2'b00,2'b00, 64'h0,   6,0,64'h0);
        tbl[3]  = mk(1, 64'h1018, 64'h55, 8'h01, 0,0,0,0,0,0, 2'b10,2'b00, 64'h0,                   3,1,64'h0);
        tbl[4]  = mk(0, 64'h1020, 64'h0, 8'h00, 0,0,0,0,0,0, 2'b00,2'b11, 64'hAAAA5555_0000FFFF,     3,1,64'hAAAA5555_0000FFFF);
        tbl[5]  = mk(0, 64'h1028, 64'h0, 8'h00, 0,0,0,0,0,0, 2'b00,2'b00, 64'h0F0F,                  3,0,64'h0F0F);
        tbl[6]  = mk(0, 64'h1003, 64'h0, 8'h00, 0,0,0,0,0,0, 2'b00,2'b00, 64'h9999,                  1,1,64'h0);
        tbl[7]  = mk(1, 64'h1004, 64'hFFFF, 8'hFF, 0,0,0,0,0,0, 2'b00,2'b00, 64'h0,                  1,1,64'h0);
        tbl[8]  = mk(0, 64'h1030, 64'h0, 8'h00, 0,0,0,0,0,2, 2'b00,2'b00, 64'hBEEF,                  5,1,64'hBEEF);
        tbl[9]  = mk(1, 64'h1038, 64'h77, 8'h0F, 1,2,0,2,0,0, 2'b01,2'b00, 64'h0,                    7,0,64'h0);
        tbl[10] = mk(0, 64'h1040, 64'h0, 8'h00, 0,0,0,0,2,0, 2'b00,2'b01, 64'hC0FFEE,                5,0,64'hC0FFEE);

        srst = 1'b1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
        aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; b_resp = '0;
        r_valid = 0; r_data = '0; r_resp = '0; r_last = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", 128'({req_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_err}), 128'(0));
        check("reset data", 128'({rsp_rdata, aw_addr}), 128'(0));
        check("reset wbeat", 128'({w_data, w_strb, w_last}), 128'({64'h0, 8'h0, 1'b1}));
        srst = 1'b0;
        @(negedge clk);
        check("idle ready", 128'(req_ready), 128'(1));

        for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for B: a stray B must not be consumed afterwards.
        req_valid = 1; req_we = 1; req_addr = 64'h2000; req_wdata = 64'h1111; req_strb = 8'hFF;
        aw_ready = 1; w_ready = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        aw_ready = 0; w_ready = 0;
        check("rst wr_resp reached", 128'(b_ready), 128'(1));
        srst = 1; b_valid = 1; b_resp = 2'b10;
        @(negedge clk);
        check("rst outputs", 128'({req_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_err}), 128'(0));
        check("rst addr", 128'(aw_addr), 128'(0));
        srst = 0;
        @(negedge clk);
        check("rst release", 128'({req_ready, b_ready, rsp_valid, rsp_err}), 128'({1'b1, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        check("rst stray b", 128'({b_ready, rsp_valid}), 128'(0));
        b_valid = 0;
        run_txn(mk(0, 64'h2008, 64'h0, 8'h00, 0,0,0,0,0,0, 2'b00,2'b00, 64'h4242, 3,0,64'h4242), "post_reset_read");

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            logic [63:0] a;
            a = {$urandom(), $urandom()};
            if ($urandom_range(0, 5) != 0) a[2:0] = 3'd0;
            v = mk($urandom_range(0, 1) == 1, a, {$urandom(), $urandom()}, 8'($urandom()),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), $urandom_range(0, 2),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0,
                   2'($urandom()), 2'($urandom()), {$urandom(), $urandom()}, 0, 1'b0, 64'h0);
            run_txn(model(v), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
